if_stage: RTL and testbench

Instruction-fetch stage of the RISC-V pipeline, directly upstream of `id`. Fetches 32-bit words from instruction memory over a request/response handshake with one request in flight, and buffers them in a small FIFO. It presents one instruction per cycle to `id` as `pc_o` (fetch address + 4, the convention `id` uses for link and branch-target arithmetic), `inst_o` and `ignore_o`. It accepts redirects from `id` (`jump_o`/`jump_addr_o`) and flushes all wrong-path state.

---
 rtl/if_stage_pkg.sv | 25 ++
 rtl/if_stage_fetch_fifo.sv | 78 +++++++
 rtl/if_stage.sv | 146 ++++++++++++++
 tb/tb_if_stage.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared widths, IF state encodings and the fetch-buffer payload for the fetch stage.
package if_stage_pkg;

  localparam int unsigned InstAddrW = 32;
  localparam int unsigned InstW     = 32;

  localparam logic [InstW-1:0] ZeroWord  = 32'h0;
  localparam logic             RstEnable = 1'b1;
  localparam logic             True      = 1'b1;
  localparam logic             False     = 1'b0;

  typedef enum logic [1:0] {
    IfIdle  = 2'd0,
    IfWait  = 2'd1,
    IfDrain = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [InstAddrW-1:0] pc;
    logic [InstW-1:0]     inst;
  } fetch_entry_t;

  localparam int unsigned EntryW = $bits(fetch_entry_t);

endpackage

// File: rtl/if_stage_fetch_fifo.sv
// Small synchronous FIFO of {pc, inst} entries; flush dominates a same-cycle push.
module if_stage_fetch_fifo
  import if_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_i,
  input  logic [EntryW-1:0]              data_i,
  input  logic                           pop_i,
  input  logic                           flush_i,
  output logic [EntryW-1:0]              head_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output logic                           empty_o,
  output logic                           full_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  fetch_entry_t    mem_q [DEPTH];
  fetch_entry_t    mem_d [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            wr_en_c, rd_en_c;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    rd_en_c  = pop_i && !empty_o;
    wr_en_c  = push_i && (!full_o || rd_en_c);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en_c) begin
        mem_d[wr_ptr_q] = fetch_entry_t'(data_i);
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (rd_en_c) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CntW'(wr_en_c) - CntW'(rd_en_c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: one-in-flight memory fetch FSM, fetch buffer and the
// registered {pc+4, inst, ignore} slot presented to id.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        ignore_o
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  if_state_e            state_q, state_d;
  logic [InstAddrW-1:0] fetch_pc_q, fetch_pc_d;
  logic [InstAddrW-1:0] req_pc_q, req_pc_d;
  logic [InstAddrW-1:0] pc_q, pc_d;
  logic [InstW-1:0]     inst_q, inst_d;
  logic                 ignore_q, ignore_d;

  logic                 redirect_c, req_c, push_c, pop_c;
  logic                 fifo_empty_c, fifo_full_c;
  logic [CntW-1:0]      count_c, occ_c;
  fetch_entry_t         head_c, push_entry_c;

  assign redirect_c = jump_i && !stall_i;
  // A pop in the response cycle frees a slot, which keeps back-to-back fetch going.
  assign occ_c      = count_c - CntW'(pop_c);

  assign push_entry_c.pc   = req_pc_q + 32'd4;
  assign push_entry_c.inst = mem_data_i;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    req_c      = 1'b0;
    push_c     = 1'b0;
    unique case (state_q)
      IfIdle: begin
        req_c = !fifo_full_c && !redirect_c;
        if (req_c && mem_ready_i) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = IfWait;
        end
      end
      IfWait: begin
        if (redirect_c) begin
          state_d = mem_valid_i ? IfIdle : IfDrain;
        end else if (mem_valid_i) begin
          push_c = 1'b1;
          req_c  = (occ_c < CntW'(FIFO_DEPTH - 1));
          if (req_c && mem_ready_i) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end else begin
            state_d = IfIdle;
          end
        end
      end
      IfDrain: begin
        if (mem_valid_i) begin
          state_d = IfIdle;
        end
      end
      default: state_d = IfIdle;
    endcase
    if (redirect_c) begin
      fetch_pc_d = jump_addr_i;
    end
  end

  always_comb begin
    pc_d     = pc_q;
    inst_d   = inst_q;
    ignore_d = ignore_q;
    pop_c    = 1'b0;
    if (!stall_i) begin
      if (redirect_c) begin
        inst_d   = ZeroWord;
        ignore_d = True;
      end else if (!fifo_empty_c) begin
        pop_c    = 1'b1;
        pc_d     = head_c.pc;
        inst_d   = head_c.inst;
        ignore_d = False;
      end else begin
        inst_d   = ZeroWord;
        ignore_d = True;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q    <= IfIdle;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= ZeroWord;
      pc_q       <= ZeroWord;
      inst_q     <= ZeroWord;
      ignore_q   <= True;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      ignore_q   <= ignore_d;
    end
  end

  if_stage_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .data_i  (push_entry_c),
    .pop_i   (pop_c),
    .flush_i (redirect_c),
    .head_o  (head_c),
    .count_o (count_c),
    .empty_o (fifo_empty_c),
    .full_o  (fifo_full_c)
  );

  assign mem_req_o  = req_c && (rst != RstEnable);
  assign mem_addr_o = fetch_pc_q;
  assign pc_o       = pc_q;
  assign inst_o     = inst_q;
  assign ignore_o   = ignore_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: memory model with programmable latency, and a scoreboard of
// expected {pc+4, inst} slots pushed on accepted responses and popped on output.
module tb_if_stage;

  localparam logic [31:0] TbResetPc = 32'h0;
  localparam logic [31:0] DataKey   = 32'h5A5A_A5A5;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        jump_i = 1'b0;
  logic [31:0] jump_addr_i = 32'h0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i = 1'b1;
  logic        mem_valid_i = 1'b0;
  logic [31:0] mem_data_i = 32'h0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        ignore_o;

  if_stage #(
    .FIFO_DEPTH (2),
    .RESET_PC   (TbResetPc)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .jump_i      (jump_i),
    .jump_addr_i (jump_addr_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ready_i (mem_ready_i),
    .mem_valid_i (mem_valid_i),
    .mem_data_i  (mem_data_i),
    .pc_o        (pc_o),
    .inst_o      (inst_o),
    .ignore_o    (ignore_o)
  );

  always #5 clk = ~clk;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_cd = 0;
  int          pend_epoch = 0;
  logic [31:0] resp_addr = 32'h0;
  logic [31:0] resp_data = 32'h0;
  int          resp_epoch = 0;
  int          epoch = 0;
  logic [31:0] exp_fetch = TbResetPc;
  int          mem_lat = 1;
  logic        nop_mode = 1'b1;
  int          rdy_mode = 0;

  logic        prev_rst = 1'b1;
  logic        prev_stall = 1'b0;
  logic        prev_redir = 1'b0;
  logic        prev_nonempty = 1'b0;
  logic [31:0] last_pc = 32'h0;
  logic [31:0] last_inst = 32'h0;
  logic        last_ign = 1'b1;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return nop_mode ? 32'h0000_0013 : (a ^ DataKey);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Output slot checks, then memory/scoreboard bookkeeping for the coming edge.
  task automatic monitor();
    logic redir;
    exp_t e;
    redir = jump_i && !stall_i && !rst;
    if (prev_rst) begin
      check("rst_pc", pc_o, 32'h0);
      check("rst_inst", inst_o, 32'h0);
      check("rst_ign", 32'(ignore_o), 32'h1);
    end else if (prev_stall) begin
      check("hold_pc", pc_o, last_pc);
      check("hold_inst", inst_o, last_inst);
      check("hold_ign", 32'(ignore_o), 32'(last_ign));
    end else if (prev_redir) begin
      check("redir_bubble_ign", 32'(ignore_o), 32'h1);
      check("redir_bubble_inst", inst_o, 32'h0);
    end else begin
      check("ignore", 32'(ignore_o), 32'(!prev_nonempty));
      if (!ignore_o) begin
        check("sb_avail", 32'(sb_q.size() != 0), 32'h1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("out_pc", pc_o, e.pc);
          check("out_inst", inst_o, e.inst);
        end
      end else begin
        check("bubble_pc", pc_o, last_pc);
        check("bubble_inst", inst_o, 32'h0);
      end
    end

    if (rst) begin
      check("req_in_rst", 32'(mem_req_o), 32'h0);
      pend = 1'b0;
      sb_q.delete();
      epoch++;
      exp_fetch = TbResetPc;
      prev_nonempty = 1'b0;
    end else begin
      prev_nonempty = (sb_q.size() != 0);
      if (mem_valid_i && (resp_epoch == epoch) && !redir) begin
        e.pc   = resp_addr + 32'd4;
        e.inst = resp_data;
        sb_q.push_back(e);
      end
      if (redir) begin
        check("req_on_redir", 32'(mem_req_o), 32'h0);
        sb_q.delete();
        epoch++;
        exp_fetch = jump_addr_i;
      end else if (mem_req_o && mem_ready_i) begin
        check("fetch_addr", mem_addr_o, exp_fetch);
        check("one_inflight", 32'(pend), 32'h0);
        pend       = 1'b1;
        pend_addr  = exp_fetch;
        pend_cd    = mem_lat;
        pend_epoch = epoch;
        exp_fetch  = exp_fetch + 32'd4;
      end
    end

    prev_rst   = rst;
    prev_stall = stall_i && !rst;
    prev_redir = redir;
    last_pc    = pc_o;
    last_inst  = inst_o;
    last_ign   = ignore_o;
  endtask

  task automatic cycle(input logic r, input logic s, input logic j, input logic [31:0] ja);
    @(posedge clk);
    #1;
    mem_valid_i = 1'b0;
    if (pend) begin
      if (pend_cd <= 1) begin
        mem_valid_i = 1'b1;
        mem_data_i  = word_at(pend_addr);
        resp_addr   = pend_addr;
        resp_data   = mem_data_i;
        resp_epoch  = pend_epoch;
        pend        = 1'b0;
      end else begin
        pend_cd--;
      end
    end
    rst         = r;
    stall_i     = s;
    jump_i      = j;
    jump_addr_i = ja;
    case (rdy_mode)
      0:       mem_ready_i = 1'b1;
      1:       mem_ready_i = 1'($urandom_range(0, 1));
      default: mem_ready_i = 1'b0;
    endcase
    @(negedge clk);
    monitor();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic wait_valid(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      seen = !ignore_o;
    end
    check({tag, "_timeout"}, 32'(seen), 32'h1);
  endtask

  task automatic wait_req(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      seen = mem_req_o;
    end
    check({tag, "_timeout"}, 32'(seen), 32'h1);
  endtask

  initial begin
    // Reset, then back-to-back fetch with a 1-cycle nop memory.
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check("c0_req", 32'(mem_req_o), 32'h1);
    check("c0_addr", mem_addr_o, TbResetPc);
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      check("steady_req", 32'(mem_req_o), 32'h1);
      check("steady_addr", mem_addr_o, 32'(4 * i));
      if (i == 2) check("c2_ign", 32'(ignore_o), 32'h1);
      if (i >= 3) begin
        check("first_ign", 32'(ignore_o), 32'h0);
        check("first_pc", pc_o, 32'(4 * (i - 2)));
        check("first_inst", inst_o, 32'h0000_0013);
      end
    end

    // Four-cycle stall in steady flow: buffer fills, requests stop, order kept.
    nop_mode = 1'b0;
    run(3);
    repeat (4) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("stall_req_drop", 32'(mem_req_o), 32'h0);
    run(8);

    // Redirect in the cycle the word at 0x10 returns.
    do_reset();
    run(5);
    cycle(1'b0, 1'b0, 1'b1, 32'h100);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check("redir_req", 32'(mem_req_o), 32'h1);
    check("redir_addr", mem_addr_o, 32'h100);
    wait_valid("redir");
    check("redir_pc", pc_o, 32'h104);
    check("redir_inst", inst_o, 32'h100 ^ DataKey);

    // Redirect in WAIT with a 3-cycle memory goes through DRAIN.
    mem_lat = 3;
    do_reset();
    run(1);
    cycle(1'b0, 1'b0, 1'b1, 32'h200);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check("drain_noreq2", 32'(mem_req_o), 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check("drain_noreq3", 32'(mem_req_o), 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check("drain_req", 32'(mem_req_o), 32'h1);
    check("drain_addr", mem_addr_o, 32'h200);
    wait_valid("drain");
    check("drain_pc", pc_o, 32'h204);

    // A second redirect while draining retargets the fetch.
    do_reset();
    run(1);
    cycle(1'b0, 1'b0, 1'b1, 32'h400);
    cycle(1'b0, 1'b0, 1'b1, 32'h500);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check("redrain_req", 32'(mem_req_o), 32'h1);
    check("redrain_addr", mem_addr_o, 32'h500);
    wait_valid("redrain");
    check("redrain_pc", pc_o, 32'h504);

    // Reset asserted with a request in flight.
    wait_req("pre_rst");
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check("post_rst_req", 32'(mem_req_o), 32'h1);
    check("post_rst_addr", mem_addr_o, TbResetPc);

    // Fetch address wrap at the top of the address space.
    mem_lat = 1;
    run(4);
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    wait_req("wrap");
    check("wrap_addr0", mem_addr_o, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check("wrap_addr1", mem_addr_o, 32'h0);
    wait_valid("wrap");
    check("wrap_pc", pc_o, 32'h0);
    check("wrap_inst", inst_o, 32'hFFFF_FFFC ^ DataKey);

    // Random stalls, redirects, ready and memory latency.
    rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      mem_lat = $urandom_range(1, 3);
      cycle(1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
            $urandom & 32'hFFFF_FFFC);
    end

    // Stop accepting requests and let everything buffered reach the output.
    rdy_mode = 2;
    run(10);
    check("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
